// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : control_pkg
//  Brief    : Shared encodings for the multicycle RV32I main controller.
//  Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

    typedef enum logic [4:0] {
        S_RESET    = 5'd0,
        S_FETCH    = 5'd1,
        S_DECODE   = 5'd2,
        S_MEMADR   = 5'd3,
        S_MEMREAD  = 5'd4,
        S_MEMWB    = 5'd5,
        S_MEMWRITE = 5'd6,
        S_EXECR    = 5'd7,
        S_EXECI    = 5'd8,
        S_ALUWB    = 5'd9,
        S_JAL      = 5'd10,
        S_JALR     = 5'd11,
        S_LINK     = 5'd12,
        S_BRANCH   = 5'd13,
        S_LUI      = 5'd14,
        S_AUIPC    = 5'd15,
        S_TRAP     = 5'd16
    } state_t;

    typedef enum logic [1:0] {
        CLS_OTHER  = 2'd0,
        CLS_R      = 2'd1,
        CLS_I      = 2'd2,
        CLS_BRANCH = 2'd3
    } instr_class_t;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_DMEM   = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;
    localparam logic [1:0] RES_IMM    = 2'd3;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    typedef struct packed {
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_ITYPE, OP_JALR: return IMM_I;
            OP_STORE:                   return IMM_S;
            OP_BRANCH:                  return IMM_B;
            OP_JAL:                     return IMM_J;
            OP_LUI, OP_AUIPC:           return IMM_U;
            default:                    return 3'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : alu_decoder
//  Brief    : Maps instruction class and funct fields to an ALU operation.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import control_pkg::*;
(
    input  logic [1:0] i_cls,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        if (i_cls == CLS_BRANCH) begin
            // Equality compares via SUB; ordered compares via the SLT flavours.
            case (i_funct3)
                3'd0, 3'd1: o_alu_control = ALU_SUB;
                3'd4, 3'd5: o_alu_control = ALU_SLT;
                3'd6, 3'd7: o_alu_control = ALU_SLTU;
                default:    o_alu_control = ALU_ADD;
            endcase
        end else if ((i_cls == CLS_R) || (i_cls == CLS_I)) begin
            case (i_funct3)
                3'd0:    o_alu_control = ((i_cls == CLS_R) && i_funct7_5) ? ALU_SUB : ALU_ADD;
                3'd1:    o_alu_control = ALU_SLL;
                3'd2:    o_alu_control = ALU_SLT;
                3'd3:    o_alu_control = ALU_SLTU;
                3'd4:    o_alu_control = ALU_XOR;
                3'd5:    o_alu_control = i_funct7_5 ? ALU_SRA : ALU_SRL;
                3'd6:    o_alu_control = ALU_OR;
                default: o_alu_control = ALU_AND;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Brief    : Multicycle RV32I main controller (Moore FSM, Mealy branch term).
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op_code,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       Zero,
    output logic       adr_src,
    output logic       mem_write,
    output logic       IR_write,
    output logic       reg_write,
    output logic       PC_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next_state;
    ctrl_t      r_ctrl;
    logic [1:0] w_cls;
    logic [3:0] w_alu_op;
    logic       w_branch_ok;
    logic       w_branch_taken;
    logic       w_unused;

    assign w_unused = &{1'b0, funct7[6], funct7[4:0]};

    always_comb begin
        case (op_code)
            OP_RTYPE:  w_cls = CLS_R;
            OP_ITYPE:  w_cls = CLS_I;
            OP_BRANCH: w_cls = CLS_BRANCH;
            default:   w_cls = CLS_OTHER;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_cls         (w_cls),
        .i_funct3      (funct3),
        .i_funct7_5    (funct7[5]),
        .o_alu_control (w_alu_op)
    );

    // funct3 2/3 are not branches; the others take on Zero or its inverse.
    assign w_branch_ok    = (funct3 != 3'd2) && (funct3 != 3'd3);
    assign w_branch_taken = (funct3[2] ^ funct3[0]) ? ~Zero : Zero;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET:    w_next_state = S_FETCH;
            S_FETCH:    w_next_state = S_DECODE;
            S_DECODE: begin
                case (op_code)
                    OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
                    OP_RTYPE:          w_next_state = S_EXECR;
                    OP_ITYPE:          w_next_state = S_EXECI;
                    OP_JAL:            w_next_state = S_JAL;
                    OP_JALR:           w_next_state = S_JALR;
                    OP_BRANCH:         w_next_state = S_BRANCH;
                    OP_LUI:            w_next_state = S_LUI;
                    OP_AUIPC:          w_next_state = S_AUIPC;
                    default:           w_next_state = S_TRAP;
                endcase
            end
            S_MEMADR:   w_next_state = (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: w_next_state = S_FETCH;
            S_EXECR:    w_next_state = S_ALUWB;
            S_EXECI:    w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_JALR:     w_next_state = S_LINK;
            S_LINK:     w_next_state = S_ALUWB;
            S_BRANCH:   w_next_state = w_branch_ok ? S_FETCH : S_TRAP;
            S_LUI:      w_next_state = S_FETCH;
            S_AUIPC:    w_next_state = S_ALUWB;
            S_TRAP:     w_next_state = S_TRAP;
            default:    w_next_state = S_TRAP;
        endcase
    end

    // Control word for a state; registered on entry so outputs depend on state only.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [3:0] alu_op);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write    = 1'b1;
                c.alu_src_a   = SRCA_PC;
                c.alu_src_b   = SRCB_FOUR;
                c.alu_control = ALU_ADD;
                c.result_src  = RES_ALURES;
                c.pc_write    = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RS1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
            end
            S_MEMWB: begin
                c.result_src = RES_DMEM;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src    = 1'b1;
                c.result_src = RES_ALUOUT;
                c.mem_write  = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.alu_control = alu_op;
            end
            S_EXECI: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_IMM;
                c.alu_control = alu_op;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALUOUT;
                c.pc_write   = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = SRCA_RS1;
                c.alu_src_b  = SRCB_IMM;
                c.result_src = RES_ALURES;
                c.pc_write   = 1'b1;
            end
            S_LINK: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
            end
            S_BRANCH: begin
                c.alu_src_a   = SRCA_RS1;
                c.alu_src_b   = SRCB_RS2;
                c.result_src  = RES_ALUOUT;
                c.alu_control = alu_op;
            end
            S_LUI: begin
                c.result_src = RES_IMM;
                c.reg_write  = 1'b1;
            end
            S_AUIPC: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
            end
            S_TRAP: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next_state;
            r_ctrl  <= ctrl_for(w_next_state, w_alu_op);
        end
    end

    assign adr_src     = r_ctrl.adr_src;
    assign mem_write   = r_ctrl.mem_write;
    assign IR_write    = r_ctrl.ir_write;
    assign reg_write   = r_ctrl.reg_write;
    assign result_src  = r_ctrl.result_src;
    assign alu_src_a   = r_ctrl.alu_src_a;
    assign alu_src_b   = r_ctrl.alu_src_b;
    assign alu_control = r_ctrl.alu_control;
    assign illegal     = r_ctrl.illegal;

    // Branch PC load is the only output that sees same-cycle Zero.
    assign PC_write = r_ctrl.pc_write
                    | ((r_state == S_BRANCH) & w_branch_ok & w_branch_taken);

    assign imm_src = reset ? imm_src_of(op_code) : 3'd0;

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Multicycle RV32I main controller, directly upstream of the datapath. Consumes the decoded `op_code`/`funct3`/`funct7` fields and the ALU `Zero` flag. Drives every datapath enable and mux select through a Moore state machine with a small Mealy branch term. Sequences each instruction as FETCH → DECODE → class-specific states → FETCH.

## Interface
- No parameters; all encodings are fixed in `control_pkg`.
- `clk` in 1: system clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low. State goes to `S_RESET` immediately on assertion.
- `op_code` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `funct7` in 7: `instr[31:25]`.
- `Zero` in 1: ALU result equals zero.
- `adr_src` out 1: memory address select. 0 = PC, 1 = result.
- `mem_write` out 1: data memory write strobe.
- `IR_write` out 1: loads the instruction register and the old-PC register.
- `reg_write` out 1: register file write strobe.
- `PC_write` out 1: loads the PC from result.
- `result_src` out 2: result mux select. 0 = ALU_out, 1 = dmem_data, 2 = ALU_result, 3 = immed_extend.
- `alu_src_a` out 2: ALU A select. 0 = PC, 1 = old_PC, 2 = rs1 (A flop).
- `alu_src_b` out 2: ALU B select. 0 = rs2 (B flop), 1 = immediate, 2 = constant 4.
- `imm_src` out 3: immediate format. I = 0, S = 1, B = 2, J = 3, U = 4.
- `alu_control` out 4: ALU operation. ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- `illegal` out 1: sticky unsupported-opcode flag.

## Operation
- **Defaults:** all strobes are 0 and all selects are 0 unless a state lists them.
- **`imm_src`:** a combinational function of `op_code` in every state.
  - I for 0x03, 0x13, 0x67.
  - S for 0x23.
  - B for 0x63.
  - J for 0x6F.
  - U for 0x37, 0x17.
  - Any other opcode gives 0.
- **S_RESET:** no strobes. Goes to FETCH on the first edge after `reset` is released.
- **FETCH:** `adr_src`=0, `IR_write`=1, `alu_src_a`=0, `alu_src_b`=2, ADD, `result_src`=2, `PC_write`=1. Goes to DECODE.
- **DECODE:** `alu_src_a`=1, `alu_src_b`=1, ADD (ALU_out becomes the PC-relative target). Next state by opcode:
  - 0x03 / 0x23 → MEMADR
  - 0x33 → EXECR
  - 0x13 → EXECI
  - 0x6F → JAL
  - 0x67 → JALR
  - 0x63 → BRANCH
  - 0x37 → LUI
  - 0x17 → AUIPC
  - any other → TRAP
- **MEMADR:** `alu_src_a`=2, `alu_src_b`=1, ADD. Goes to MEMREAD for a load, MEMWRITE for a store.
- **MEMREAD:** `adr_src`=1, `result_src`=0. Goes to MEMWB.
- **MEMWB:** `result_src`=1, `reg_write`=1. Goes to FETCH.
- **MEMWRITE:** `adr_src`=1, `result_src`=0, `mem_write`=1. Goes to FETCH.
- **EXECR:** `alu_src_a`=2, `alu_src_b`=0, ALU op from the R-type decode. Goes to ALUWB.
- **EXECI:** `alu_src_a`=2, `alu_src_b`=1, ALU op from the I-type decode. Goes to ALUWB.
- **ALUWB:** `result_src`=0, `reg_write`=1. Goes to FETCH.
- **JAL:** `alu_src_a`=1, `alu_src_b`=2, ADD, `result_src`=0, `PC_write`=1. Goes to ALUWB.
- **JALR:** `alu_src_a`=2, `alu_src_b`=1, ADD, `result_src`=2, `PC_write`=1. Goes to LINK.
- **LINK:** `alu_src_a`=1, `alu_src_b`=2, ADD. Goes to ALUWB.
- **BRANCH:** `alu_src_a`=2, `alu_src_b`=0, `result_src`=0, `PC_write`=taken. Goes to FETCH.
  - beq: SUB, taken = `Zero`.
  - bne: SUB, taken = !`Zero`.
  - blt: SLT, taken = !`Zero`.
  - bge: SLT, taken = `Zero`.
  - bltu: SLTU, taken = !`Zero`.
  - bgeu: SLTU, taken = `Zero`.
  - funct3 2 or 3 goes to TRAP with no PC write.
- **LUI:** `result_src`=3, `reg_write`=1. Goes to FETCH.
- **AUIPC:** `alu_src_a`=1, `alu_src_b`=1, ADD. Goes to ALUWB.
- **TRAP:** no strobes, `illegal`=1. Stays in TRAP until reset.
- **ALU decode, funct3 to op:**
  - 0 → ADD, or SUB when R-type and `funct7[5]`=1.
  - 1 → SLL.
  - 2 → SLT.
  - 3 → SLTU.
  - 4 → XOR.
  - 5 → SRL, or SRA when `funct7[5]`=1 (R-type and I-type shifts).
  - 6 → OR.
  - 7 → AND.
- **addi:** `funct7` bits are immediate bits, so they never select SUB.

## Timing
- **Reset values, while `reset`=0:** state S_RESET, every output 0, `illegal`=0.
- **Reset mid-instruction:** every strobe, including `mem_write` and `PC_write`, deasserts combinationally with the reset assertion, not at the next edge.
- **Cycles per instruction, FETCH to next FETCH:**
  - LUI 3, branch 3.
  - R-type 4, I-type ALU 4, store 4, JAL 4, AUIPC 4.
  - load 5, JALR 5.
- **Strobe widths:** `IR_write`, `mem_write` and `reg_write` are each high for exactly one cycle per instruction. `PC_write` is high at most twice (FETCH plus jump/branch).
- **Output timing:** all outputs except BRANCH `PC_write` are a pure function of registered state. BRANCH `PC_write` also depends on the same-cycle `Zero`.

## Structure
- **`control_pkg`:** holds the state enum, opcode localparams, ALU op codes, `imm_src` codes, and the `result_src`/`alu_src_a`/`alu_src_b` select codes.
- **Sub-module `alu_decoder`:** combinational; inputs instruction class, `funct3`, `funct7[5]`; output `alu_control`.
- **`control_unit`:** holds the state register, next-state logic, output logic and the `imm_src` decode.

## Test plan
- **Reset release:** hold `reset`=0 for 3 cycles, then release → one S_RESET cycle, then FETCH with `IR_write`=1, `PC_write`=1, `alu_src_b`=2, `alu_control`=0.
- **R-type:**
  - add 0x002081B3 → FETCH, DECODE, EXECR (`alu_control`=0), ALUWB (`reg_write`=1). 4 cycles, `reg_write` high exactly once.
  - sub 0x40208133 → SUB in EXECR.
- **Shift and addi decode:**
  - srai 0x4020D093 → SRA (7).
  - addi 0x40008093 (imm bit 10 set) → ADD (0), not SUB.
- **Branches:**
  - beq with `Zero`=1 → `PC_write`=1 in BRANCH.
  - bne with `Zero`=1 → `PC_write`=0.
  - blt with `Zero`=0 → `PC_write`=1.
  - All three take 3 cycles.
- **Memory:**
  - lw → 5 cycles; `adr_src`=1 in MEMREAD; `reg_write`=1 with `result_src`=1 in MEMWB; `mem_write` never asserted.
  - sw → `mem_write` high exactly one cycle.
  - Assert `reset` during MEMWRITE → `mem_write` drops the same cycle.
- **Illegal opcode and jumps:**
  - opcode 0x7F → TRAP; `illegal`=1 and all strobes 0 for 20 cycles until reset.
  - JALR → 5 cycles with `PC_write` in FETCH and JALR only.
